// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder
// Decodes the 4-bit Johnson ring-counter state into a 3-bit phase index. It
// checks that each new code is a stall or a +1 advance of the previous one,
// locks after LOCK_CNT clean advances, and reports locked 7->0 wraps.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   jc_in        Johnson counter state, sampled every clock
//   phase        decoded phase of the last legal code
//   locked       sequence tracked and trusted
//   wrap         one-cycle pulse on a locked 7->0 advance
//   cycle_count  number of locked wraps since reset (modulo 2^CNT_W)
//   illegal      jc_in was not a Johnson code
//   seq_err      legal code that was neither a stall nor a +1 advance
//
// All outputs are registered, so each one reflects the jc_in sampled at the
// previous edge.
//
// Optional build macro: JOHNSON_PHASE_DECODER_STICKY_ERR_EN
//   Defined:   the first error moves the FSM to FAULT. Both error flags latch
//              until rst, locking is inhibited, and wrap/cycle_count freeze.
//   Undefined: the error flags are single-cycle pulses and the block relocks.
module johnson_phase_decoder #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       jc_in,
    output logic [2:0]       phase,
    output logic             locked,
    output logic             wrap,
    output logic [CNT_W-1:0] cycle_count,
    output logic             illegal,
    output logic             seq_err
);

    localparam int unsigned MATCH_W = 4;
    localparam int unsigned PHASE_W = 3;

`ifdef JOHNSON_PHASE_DECODER_STICKY_ERR_EN
    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;
`else
    typedef enum logic {
        ST_UNLOCK = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;
`endif

    state_e               state_q, state_d;
    logic                 first_q, first_d;
    logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic                 locked_q, locked_d;
    logic                 wrap_q, wrap_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 illegal_q, illegal_d;
    logic                 seq_err_q, seq_err_d;

    logic                 legal_c;
    logic [PHASE_W-1:0]   new_phase_c;
    logic [PHASE_W-1:0]   delta_c;

    // Johnson code to phase lookup; the remaining 8 codes are illegal.
    always_comb begin
        legal_c     = 1'b1;
        new_phase_c = 3'd0;
        case (jc_in)
            4'b0000: new_phase_c = 3'd0;
            4'b0001: new_phase_c = 3'd1;
            4'b0011: new_phase_c = 3'd2;
            4'b0111: new_phase_c = 3'd3;
            4'b1111: new_phase_c = 3'd4;
            4'b1110: new_phase_c = 3'd5;
            4'b1100: new_phase_c = 3'd6;
            4'b1000: new_phase_c = 3'd7;
            default: legal_c     = 1'b0;
        endcase
    end

    // Modulo-8 distance from the last legal phase, via 3-bit wraparound.
    assign delta_c = new_phase_c - phase_q;

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        match_cnt_d = match_cnt_q;
        phase_d     = phase_q;
        wrap_d      = 1'b0;
        cnt_d       = cnt_q;
`ifdef JOHNSON_PHASE_DECODER_STICKY_ERR_EN
        illegal_d   = illegal_q;
        seq_err_d   = seq_err_q;
`else
        illegal_d   = 1'b0;
        seq_err_d   = 1'b0;
`endif

        if (!legal_c) begin
            // Phase holds; the next legal code restarts tracking as a first sample.
            illegal_d   = 1'b1;
            first_d     = 1'b1;
            match_cnt_d = '0;
`ifdef JOHNSON_PHASE_DECODER_STICKY_ERR_EN
            state_d     = ST_FAULT;
`else
            state_d     = ST_UNLOCK;
`endif
        end else if (first_q) begin
            phase_d = new_phase_c;
            first_d = 1'b0;
        end else if (delta_c == 3'd0) begin
            // Stall: nothing changes.
        end else if (delta_c == 3'd1) begin
            phase_d = new_phase_c;
            case (state_q)
                ST_UNLOCK: begin
                    match_cnt_d = match_cnt_q + MATCH_W'(1);
                    if ((match_cnt_q + MATCH_W'(1)) == MATCH_W'(LOCK_CNT)) begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (phase_q == 3'd7) begin
                        wrap_d = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end else begin
            seq_err_d   = 1'b1;
            phase_d     = new_phase_c;
            match_cnt_d = '0;
`ifdef JOHNSON_PHASE_DECODER_STICKY_ERR_EN
            state_d     = ST_FAULT;
`else
            state_d     = ST_UNLOCK;
`endif
        end

        // locked mirrors the state being entered so it moves in the same output cycle.
        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_UNLOCK;
            first_q     <= 1'b1;
            match_cnt_q <= '0;
            phase_q     <= '0;
            locked_q    <= 1'b0;
            wrap_q      <= 1'b0;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            match_cnt_q <= match_cnt_d;
            phase_q     <= phase_d;
            locked_q    <= locked_d;
            wrap_q      <= wrap_d;
            cnt_q       <= cnt_d;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign phase       = phase_q;
    assign locked      = locked_q;
    assign wrap        = wrap_q;
    assign cycle_count = cnt_q;
    assign illegal     = illegal_q;
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Self-checking bench for johnson_phase_decoder: a phase-arithmetic model
// checked every cycle, plus hand-computed literal expectations.
module tb_johnson_phase_decoder;

    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned CNT_W    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       jc_in;
    logic [2:0]       phase;
    logic             locked;
    logic             wrap;
    logic [CNT_W-1:0] cycle_count;
    logic             illegal;
    logic             seq_err;

    johnson_phase_decoder #(.LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .jc_in       (jc_in),
        .phase       (phase),
        .locked      (locked),
        .wrap        (wrap),
        .cycle_count (cycle_count),
        .illegal     (illegal),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    logic [3:0] jtab [8];
    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state: expected outputs plus tracking info.
    int e_phase, e_cnt, m_run;
    bit e_locked, e_wrap, e_illegal, e_seq, m_first, m_fault;

    function automatic int code_index(input logic [3:0] c);
        for (int i = 0; i < 8; i++) if (jtab[i] == c) return i;
        return -1;
    endfunction

    task automatic model_update(input logic [3:0] c, input logic r);
        int idx;
        int d;
        if (r) begin
            e_phase = 0; e_cnt = 0; m_run = 0; e_locked = 0; e_wrap = 0;
            e_illegal = 0; e_seq = 0; m_first = 1; m_fault = 0;
            return;
        end
        idx    = code_index(c);
        e_wrap = 0;
`ifndef JOHNSON_PHASE_DECODER_STICKY_ERR_EN
        e_illegal = 0;
        e_seq     = 0;
`endif
        if (idx < 0) begin
            e_illegal = 1; m_first = 1; m_run = 0;
`ifdef JOHNSON_PHASE_DECODER_STICKY_ERR_EN
            m_fault = 1;
`endif
        end else if (m_first) begin
            e_phase = idx; m_first = 0;
        end else begin
            d = (idx - e_phase + 8) % 8;
            if (d == 1) begin
                if (!m_fault) begin
                    // Already locked before this edge and crossing 7->0.
                    if (m_run >= int'(LOCK_CNT) && e_phase == 7) begin
                        e_wrap = 1;
                        e_cnt  = (e_cnt + 1) % (1 << CNT_W);
                    end
                    if (m_run < 1000) m_run++;
                end
                e_phase = idx;
            end else if (d != 0) begin
                e_seq = 1; e_phase = idx; m_run = 0;
`ifdef JOHNSON_PHASE_DECODER_STICKY_ERR_EN
                m_fault = 1;
`endif
            end
        end
        e_locked = !m_fault && (m_run >= int'(LOCK_CNT));
    endtask

    task automatic step(input logic [3:0] c, input logic r);
        @(negedge clk);
        jc_in = c;
        rst   = r;
        @(posedge clk);
        model_update(c, r);
        chk_en = 1'b1;
        #1;
    endtask

    task automatic stepi(input int idx);
        step(jtab[idx % 8], 1'b0);
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            lit("phase",       int'(phase),       e_phase);
            lit("locked",      int'(locked),      int'(e_locked));
            lit("wrap",        int'(wrap),        int'(e_wrap));
            lit("cycle_count", int'(cycle_count), e_cnt % (1 << CNT_W));
            lit("illegal",     int'(illegal),     int'(e_illegal));
            lit("seq_err",     int'(seq_err),     int'(e_seq));
            lit("flag_excl",   int'(illegal & seq_err), 0);
        end
    end

    initial begin
        jtab[0] = 4'b0000; jtab[1] = 4'b0001; jtab[2] = 4'b0011; jtab[3] = 4'b0111;
        jtab[4] = 4'b1111; jtab[5] = 4'b1110; jtab[6] = 4'b1100; jtab[7] = 4'b1000;
        rst   = 1'b1;
        jc_in = 4'b0000;

        // Reset for two cycles.
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        lit("rst_phase", int'(phase), 0);
        lit("rst_locked", int'(locked), 0);
        lit("rst_count", int'(cycle_count), 0);

        // Walk one full cycle: 0000 is the first sample, 0001..1111 are advances 1..4.
        for (int k = 0; k < 8; k++) begin
            stepi(k);
            lit("walk_phase", int'(phase), k);
            if (k == 3) lit("walk_unlocked_adv3", int'(locked), 0);
            if (k == 4) lit("walk_locked_adv4", int'(locked), 1);
            lit("walk_nowrap", int'(wrap), 0);
        end
        stepi(0);
        lit("walk_wrap", int'(wrap), 1);
        lit("walk_count1", int'(cycle_count), 1);
        stepi(1);
        lit("wrap_pulse_end", int'(wrap), 0);

        // Stall while locked.
        stepi(2);
        stepi(3);
        for (int k = 0; k < 3; k++) begin
            stepi(3);
            lit("stall_phase", int'(phase), 3);
            lit("stall_locked", int'(locked), 1);
            lit("stall_noerr", int'(seq_err | illegal), 0);
        end
        stepi(4);
        lit("stall_release", int'(phase), 4);

        // Build cycle_count up to 5, then reset mid-operation.
        for (int k = 5; k < 8 + 3 * 8; k++) stepi(k);
        stepi(0);
        lit("count5", int'(cycle_count), 5);
        lit("count5_locked", int'(locked), 1);
        step(4'b0001, 1'b1);
        lit("midrst_phase", int'(phase), 0);
        lit("midrst_locked", int'(locked), 0);
        lit("midrst_count", int'(cycle_count), 0);
        lit("midrst_flags", int'({illegal, seq_err, wrap}), 0);
        stepi(2);
        lit("post_rst_first_noerr", int'(seq_err), 0);
        lit("post_rst_first_phase", int'(phase), 2);
        stepi(3);

        // Advances 1111,1110,1100 complete the lock; 1000,0000 wrap once.
        for (int k = 4; k < 8; k++) stepi(k);
        stepi(0);
        lit("relock_count", int'(cycle_count), 1);

`ifndef JOHNSON_PHASE_DECODER_STICKY_ERR_EN
        // Skip while locked.
        stepi(1);
        stepi(2);
        stepi(4);
        lit("skip_seq_err", int'(seq_err), 1);
        lit("skip_phase", int'(phase), 4);
        lit("skip_unlocked", int'(locked), 0);
        stepi(5);
        lit("skip_pulse_end", int'(seq_err), 0);
        stepi(6);
        stepi(7);
        stepi(0);
        lit("skip_relock", int'(locked), 1);
        lit("skip_relock_nowrap", int'(wrap), 0);
        for (int k = 1; k < 8; k++) stepi(k);
        stepi(0);
        lit("skip_next_wrap", int'(wrap), 1);
        lit("skip_count2", int'(cycle_count), 2);

        // Illegal code, then 1100 taken as a first sample.
        stepi(1);
        step(4'b0101, 1'b0);
        lit("ill_flag", int'(illegal), 1);
        lit("ill_phase_hold", int'(phase), 1);
        lit("ill_unlocked", int'(locked), 0);
        step(4'b1100, 1'b0);
        lit("ill_first_phase", int'(phase), 6);
        lit("ill_first_noseq", int'(seq_err), 0);
        lit("ill_pulse_end", int'(illegal), 0);
`else
        // Sticky error: illegal latches and blocks relock for 20 clean cycles.
        step(4'b0101, 1'b0);
        lit("sticky_ill", int'(illegal), 1);
        for (int k = 1; k <= 20; k++) begin
            stepi(k);
            lit("sticky_ill_hold", int'(illegal), 1);
            lit("sticky_unlocked", int'(locked), 0);
            lit("sticky_count", int'(cycle_count), 1);
            lit("sticky_phase", int'(phase), k % 8);
        end
        stepi(20 + 3);
        lit("sticky_seq", int'(seq_err), 1);
        lit("sticky_ill_still", int'(illegal), 1);
        step(4'b0000, 1'b1);
        lit("sticky_rst_ill", int'(illegal), 0);
        lit("sticky_rst_seq", int'(seq_err), 0);
`endif

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
